// File: rtl/pyrconstuct_top_mul_pipe_us.sv
// Pipelined unsigned(din0) x signed(din1) multiply, round-half-up >>> SHIFT, narrow to OUT_W; latency NUM_STAGE cycles.
// Backpressure: all stages advance together when out_valid=0 or out_ready=1; in_ready mirrors that advance.
// Macro PYR_MUL_SAT_EN: saturate on narrowing; undefined wraps (two's-complement truncation).
module pyrconstuct_top_mul_pipe_us #(
    parameter int A_W       = 9,
    parameter int B_W       = 24,
    parameter int OUT_W     = 32,
    parameter int SHIFT     = 0,
    parameter int NUM_STAGE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout
);
    localparam int P_W = A_W + B_W + 1;
    localparam int R_W = P_W + 1;
    localparam logic [R_W:0]   RND_X = {{R_W{1'b0}}, 1'b1} << SHIFT;
    localparam logic [R_W-1:0] RND   = RND_X[R_W:1];

    logic                  adv;
    logic [NUM_STAGE-1:0]  vld_q, vld_d;
    logic signed [P_W-1:0] a_ext, b_ext, prod, p_last;
    logic signed [R_W-1:0] r_sum, r_shf;
    logic [OUT_W-1:0]      narrow, dout_q, dout_d;

    assign adv       = !vld_q[NUM_STAGE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NUM_STAGE-1];
    assign dout      = dout_q;

    assign a_ext = P_W'(din0);
    assign b_ext = P_W'($signed(din1));
    assign prod  = a_ext * b_ext;

    generate
        if (NUM_STAGE == 1) begin : g_one
            assign p_last = prod;
        end else begin : g_multi
            logic signed [P_W-1:0] p_q [NUM_STAGE-1];
            // Data registers need no reset: the valid bits alone qualify them.
            always_ff @(posedge clk) begin
                if (adv) begin
                    p_q[0] <= prod;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end
            assign p_last = p_q[NUM_STAGE-2];
        end
    endgenerate

    // One extra bit so adding the half-LSB can never overflow.
    assign r_sum = R_W'(p_last) + RND;
    assign r_shf = r_sum >>> SHIFT;

    generate
        if (OUT_W >= R_W) begin : g_ext
            assign narrow = OUT_W'(r_shf);
        end else begin : g_narrow
`ifdef PYR_MUL_SAT_EN
            logic [R_W-OUT_W:0] hi;
            assign hi     = r_shf[R_W-1:OUT_W-1];
            assign narrow = (&hi || !(|hi)) ? r_shf[OUT_W-1:0] :
                            (hi[R_W-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}});
`else
            logic unused_hi;
            assign unused_hi = ^r_shf[R_W-1:OUT_W];
            assign narrow    = r_shf[OUT_W-1:0];
`endif
        end
    endgenerate

    always_comb begin
        vld_d  = vld_q;
        dout_d = dout_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_d[i] = vld_q[i-1];
            end
            // dout only moves when a real result lands, so it holds through bubbles.
            if (vld_d[NUM_STAGE-1]) begin
                dout_d = narrow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            dout_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dout_q <= dout_d;
        end
    end
endmodule

// File: tb/tb_pyrconstuct_top_mul_pipe_us.sv
// Directed bench for the pipelined multiplier: default build, SHIFT=4/OUT_W=16 build, and a 1-stage 4x4 build.
module tb_pyrconstuct_top_mul_pipe_us;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance
    logic        v0_in, r0_in, v0_out, r0_out;
    logic [8:0]  a0;
    logic [23:0] b0;
    logic [31:0] d0;
    // SHIFT=4, OUT_W=16
    logic        v1_in, r1_in, v1_out, r1_out;
    logic [8:0]  a1;
    logic [23:0] b1;
    logic [15:0] d1;
    // NUM_STAGE=1, 4x4 -> 8
    logic        v2_in, r2_in, v2_out, r2_out;
    logic [3:0]  a2, b2;
    logic [7:0]  d2;

    pyrconstuct_top_mul_pipe_us u0 (
        .clk(clk), .reset(reset), .in_valid(v0_in), .in_ready(r0_in), .din0(a0), .din1(b0),
        .out_valid(v0_out), .out_ready(r0_out), .dout(d0));
    pyrconstuct_top_mul_pipe_us #(.SHIFT(4), .OUT_W(16)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1_in), .in_ready(r1_in), .din0(a1), .din1(b1),
        .out_valid(v1_out), .out_ready(r1_out), .dout(d1));
    pyrconstuct_top_mul_pipe_us #(.NUM_STAGE(1), .A_W(4), .B_W(4), .OUT_W(8)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2_in), .in_ready(r2_in), .din0(a2), .din1(b2),
        .out_valid(v2_out), .out_ready(r2_out), .dout(d2));

    int total = 0;
    int bad   = 0;

    typedef struct { logic [8:0] a; logic [23:0] b; logic [31:0] e; } v0_t;
    typedef struct { logic [8:0] a; logic [23:0] b; logic [15:0] e; } v1_t;
    v0_t t0 [7];
    v1_t t1 [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send0(input logic [8:0] a, input logic [23:0] b, input logic [31:0] e, input string name);
        int cyc = 0;
        a0 = a; b0 = b; v0_in = 1'b1;
        while (cyc < 10) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) v0_in = 1'b0;
            if (v0_out) break;
        end
        chk({name, " latency"}, 64'(cyc), 64'd3);
        chk({name, " dout"}, 64'(d0), 64'(e));
        @(posedge clk); #1;
        chk({name, " single pulse"}, 64'(v0_out), 64'd0);
    endtask

    task automatic send1(input logic [8:0] a, input logic [23:0] b, input logic [15:0] e, input string name);
        int cyc = 0;
        a1 = a; b1 = b; v1_in = 1'b1;
        while (cyc < 10) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) v1_in = 1'b0;
            if (v1_out) break;
        end
        chk({name, " latency"}, 64'(cyc), 64'd3);
        chk({name, " dout"}, 64'(d1), 64'(e));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q0 [$];
        logic [7:0]  q2 [$];
        logic [31:0] prev_d;
        logic        prev_stall;
        int idx, got, stalls, stale;

        t0[0] = '{9'd3,   24'hFFFFFB, 32'hFFFFFFF1};
`ifdef PYR_MUL_SAT_EN
        t0[1] = '{9'd511, 24'h800000, 32'h80000000};
        t0[2] = '{9'd511, 24'h7FFFFF, 32'h7FFFFFFF};
`else
        t0[1] = '{9'd511, 24'h800000, 32'h00800000};
        t0[2] = '{9'd511, 24'h7FFFFF, 32'hFF7FFE01};
`endif
        t0[3] = '{9'd0,   24'd12345,  32'h00000000};
        t0[4] = '{9'd1,   24'hFFFFFF, 32'hFFFFFFFF};
        t0[5] = '{9'd100, 24'd1000,   32'h000186A0};
        t0[6] = '{9'd256, 24'hFFFFFD, 32'hFFFFFD00};

        t1[0] = '{9'd1,   24'd24,     16'd2};
        t1[1] = '{9'd1,   24'hFFFFE8, 16'hFFFF};
        t1[2] = '{9'd1,   24'hFFFFE7, 16'hFFFE};
        t1[3] = '{9'd0,   24'd77,     16'd0};
        t1[4] = '{9'd3,   24'd7,      16'd1};
        t1[5] = '{9'd1,   24'd8,      16'd1};
        t1[6] = '{9'd1,   24'hFFFFF8, 16'd0};
`ifdef PYR_MUL_SAT_EN
        t1[7] = '{9'd511, 24'h7FFFFF, 16'h7FFF};
`else
        t1[7] = '{9'd511, 24'h7FFFFF, 16'hFFE0};
`endif

        reset = 1'b1;
        v0_in = 0; a0 = '0; b0 = '0; r0_out = 1'b1;
        v1_in = 0; a1 = '0; b1 = '0; r1_out = 1'b1;
        v2_in = 0; a2 = '0; b2 = '0; r2_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(v0_out), 64'd0);
        chk("reset dout", 64'(d0), 64'd0);
        chk("reset in_ready", 64'(r0_in), 64'd1);
        chk("reset u2 out_valid", 64'(v2_out), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) send0(t0[i].a, t0[i].b, t0[i].e, $sformatf("vec0[%0d]", i));
        for (int i = 0; i < 8; i++) send1(t1[i].a, t1[i].b, t1[i].e, $sformatf("vec1[%0d]", i));

        // Streaming with a four-cycle downstream stall.
        idx = 0; got = 0; stalls = 0; prev_d = '0; prev_stall = 1'b0;
        for (int c = 0; c < 80 && got < 16; c++) begin
            r0_out = !(c >= 5 && c <= 8);
            v0_in  = (idx < 16);
            a0 = 9'(idx); b0 = 24'(1000 - idx);
            #1;
            if (prev_stall && v0_out) chk("stall dout hold", 64'(d0), 64'(prev_d));
            if (v0_out && !r0_out) begin
                stalls++;
                chk("stall in_ready", 64'(r0_in), 64'd0);
            end
            if (v0_in && r0_in) begin
                q0.push_back(32'(idx * (1000 - idx)));
                idx++;
            end
            if (v0_out && r0_out) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream extra result: got %0h expected none", d0);
                end else begin
                    chk($sformatf("stream dout[%0d]", got), 64'(d0), 64'(q0.pop_front()));
                end
                got++;
            end
            prev_stall = v0_out && !r0_out;
            prev_d = d0;
            @(posedge clk); #1;
        end
        v0_in = 1'b0; r0_out = 1'b1;
        chk("stream results", 64'(got), 64'd16);
        chk("stream stall cycles", 64'(stalls), 64'd4);
        @(posedge clk); #1;

        // Reset with two results in flight.
        a0 = 9'd2; b0 = 24'd3; v0_in = 1'b1;
        @(posedge clk); #1;
        a0 = 9'd4; b0 = 24'd5;
        @(posedge clk); #1;
        v0_in = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("flush out_valid", 64'(v0_out), 64'd0);
        chk("flush dout", 64'(d0), 64'd0);
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (v0_out) stale++;
        end
        chk("flush no stale", 64'(stale), 64'd0);
        send0(9'd6, 24'd7, 32'd42, "after flush");

        // Exhaustive 4x4, single stage, random downstream backpressure.
        idx = 0; got = 0;
        for (int c = 0; c < 3000 && got < 256; c++) begin
            int ai, bi;
            ai = idx >> 4;
            bi = idx & 15;
            if (bi >= 8) bi -= 16;
            r2_out = 1'($urandom_range(0, 1));
            v2_in = (idx < 256);
            a2 = 4'(ai); b2 = 4'(bi);
            #1;
            if (v2_out && r2_out) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL exh extra result: got %0h expected none", d2);
                end else begin
                    chk($sformatf("exh dout[%0d]", got), 64'(d2), 64'(q2.pop_front()));
                end
                got++;
            end
            if (v2_in && r2_in) begin
                q2.push_back(8'(ai * bi));
                idx++;
            end
            @(posedge clk); #1;
        end
        v2_in = 1'b0;
        chk("exh results", 64'(got), 64'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
